// File: rtl/req_ack_responder_pkg.sv
// Shared types and constants for the request/acknowledge responder.
package req_ack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

   localparam int LAT_W        = 4;
   localparam int CNT_W        = 4;
   localparam int DEF_LATENCY  = 1;
   localparam int DEF_MAX_PEND = 4;

   // Countdown value loaded on entering WAIT: the cycle spent entering WAIT
   // already counts as one of the LATENCY cycles.
   function automatic logic [LAT_W-1:0] lat_reload(input int latency);
      return LAT_W'(latency - 1);
   endfunction

endpackage

// File: rtl/req_ack_responder_if.sv
// Handshake bundle between a requester (master) and the responder (slave).
interface req_ack_responder_if;
   import req_ack_pkg::*;

   logic             req;
   logic             stall;
   logic             ack;
   logic [CNT_W-1:0] pend_cnt;
   logic             busy;
   logic             overflow;

   modport master (output req, output stall,
                   input ack, input pend_cnt, input busy, input overflow);
   modport slave  (input req, input stall,
                   output ack, output pend_cnt, output busy, output overflow);
endinterface

// File: rtl/req_ack_responder_lat_timer.sv
// Latency countdown for the responder: loadable, decrements while enabled,
// saturates at zero and flags it.
module resp_lat_timer
   import req_ack_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic             zero
);

   logic [LAT_W-1:0] cnt_r;

   // Countdown register: load wins over decrement; never wraps below zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {LAT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (en && (cnt_r != {LAT_W{1'b0}})) begin
         cnt_r <= cnt_r - LAT_W'(1);
      end
   end

   assign cnt  = cnt_r;
   assign zero = (cnt_r == {LAT_W{1'b0}});

endmodule

// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: accepts one request per clock with req=1,
// queues up to MAX_PEND of them and answers each with a one-cycle ack
// LATENCY cycles later; stall holds off acks without blocking acceptance.
// Optional concurrent assertions are compiled when REQ_ACK_RESPONDER_SVA_EN
// is defined.
module req_ack_responder
   import req_ack_pkg::*;
#(
   parameter int LATENCY  = DEF_LATENCY,
   parameter int MAX_PEND = DEF_MAX_PEND
)(
   input logic           clk,
   input logic           rst,
   req_ack_responder_if.slave bus
);

   localparam logic [LAT_W-1:0] RELOAD  = lat_reload(LATENCY);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
   localparam logic             LAT_ONE = (LATENCY == 1);

   state_e           state_r, state_nxt;
   logic [CNT_W-1:0] pend_r, pend_nxt;
   logic             ack_r, busy_r, ovf_r;
   logic             retire_s, full_s, accept_s, drop_s, fast_s;
   logic             lat_load_s, lat_en_s, lat_zero_s, lat_le1_s;
   logic [LAT_W-1:0] lat_cnt_s;

   resp_lat_timer u_lat (
      .clk      (clk),
      .rst      (rst),
      .load     (lat_load_s),
      .en       (lat_en_s),
      .load_val (RELOAD),
      .cnt      (lat_cnt_s),
      .zero     (lat_zero_s)
   );

   assign lat_le1_s = lat_zero_s || (lat_cnt_s == LAT_W'(1));

   // Next-state, pending-count and latency-timer control decode.
   always_comb begin
      retire_s   = (state_r == ACK);
      full_s     = (pend_r == MAX_CNT);
      accept_s   = bus.req && (!full_s || retire_s);
      drop_s     = bus.req && full_s && !retire_s;
      pend_nxt   = pend_r + {{(CNT_W-1){1'b0}}, accept_s}
                          - {{(CNT_W-1){1'b0}}, retire_s};
      fast_s     = LAT_ONE && !bus.stall;
      state_nxt  = state_r;
      lat_load_s = 1'b0;
      lat_en_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req || (pend_r != {CNT_W{1'b0}})) begin
               if (fast_s) begin
                  state_nxt = ACK;
               end else begin
                  state_nxt  = WAIT;
                  lat_load_s = 1'b1;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            lat_en_s = 1'b1;
            if (lat_le1_s && !bus.stall) begin
               state_nxt = ACK;
            end else begin
               state_nxt = WAIT;
            end
         end
         ACK: begin
            if (pend_nxt != {CNT_W{1'b0}}) begin
               if (fast_s) begin
                  state_nxt = ACK;
               end else begin
                  state_nxt  = WAIT;
                  lat_load_s = 1'b1;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state and registered outputs. WAIT/ACK always hold at least one
   // pending request, so busy reduces to a non-zero pending count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         pend_r  <= {CNT_W{1'b0}};
         ack_r   <= 1'b0;
         busy_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_nxt;
         pend_r  <= pend_nxt;
         ack_r   <= (state_nxt == ACK);
         busy_r  <= (pend_nxt != {CNT_W{1'b0}});
         ovf_r   <= ovf_r | drop_s;
      end
   end

   assign bus.ack      = ack_r;
   assign bus.pend_cnt = pend_r;
   assign bus.busy     = busy_r;
   assign bus.overflow = ovf_r;

`ifdef REQ_ACK_RESPONDER_SVA_EN
   // With unit latency an unstalled request into an empty queue is acked next cycle.
   generate
      if (LATENCY == 1) begin : g_sva_lat1
         a_req_ack: assert property (@(posedge clk) disable iff (rst)
            (bus.req && !bus.stall && (pend_r == {CNT_W{1'b0}})) |=> bus.ack)
            else $error("req_ack_responder: req not acked next cycle at %0t", $time);
      end
   endgenerate

   // An ack is only issued for a request counted by the edge that raised it.
   a_ack_pend: assert property (@(posedge clk) disable iff (rst)
      bus.ack |-> (pend_r != {CNT_W{1'b0}}))
      else $error("req_ack_responder: ack with no pending request at %0t", $time);

   // Overflow can only rise when the queue is full.
   a_ovf_full: assert property (@(posedge clk) disable iff (rst)
      $rose(ovf_r) |-> (pend_r == MAX_CNT))
      else $error("req_ack_responder: overflow set below MAX_PEND at %0t", $time);
`else
   // Assertions not built; behaviour is identical.
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed self-checking bench: one responder with LATENCY=1, one with LATENCY=3.
module tb_req_ack_responder;
   import req_ack_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   acks;

   req_ack_responder_if if1 ();
   req_ack_responder_if if3 ();

   req_ack_responder #(.LATENCY(1), .MAX_PEND(4)) u_dut1 (
      .clk (clk), .rst (rst), .bus (if1));
   req_ack_responder #(.LATENCY(3), .MAX_PEND(4)) u_dut3 (
      .clk (clk), .rst (rst), .bus (if3));

   // 10 ns clock, first rising edge at 5 ns.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_pend [6];
      exp_pend = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4};
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      if1.req = 1'b0; if1.stall = 1'b0;
      if3.req = 1'b0; if3.stall = 1'b0;

      // Reset state
      #2;
      chk("rst_ack",  {7'd0, if1.ack},      8'd0);
      chk("rst_pend", {4'd0, if1.pend_cnt}, 8'd0);
      chk("rst_busy", {7'd0, if1.busy},     8'd0);
      chk("rst_ovf",  {7'd0, if1.overflow}, 8'd0);
      #6 rst = 1'b0;                          // t=8

      // Single pulse at 10 ns: ack high 15..25 ns
      #2 if1.req = 1'b1;                      // t=10
      chk("pulse_ack_pre", {7'd0, if1.ack}, 8'd0);
      tick();                                 // t=16
      if1.req = 1'b0;
      chk("pulse_ack",  {7'd0, if1.ack},      8'd1);
      chk("pulse_pend", {4'd0, if1.pend_cnt}, 8'd1);
      chk("pulse_busy", {7'd0, if1.busy},     8'd1);
      tick();                                 // t=26
      chk("pulse_ack_end",  {7'd0, if1.ack},      8'd0);
      chk("pulse_pend_end", {4'd0, if1.pend_cnt}, 8'd0);
      chk("pulse_ovf",      {7'd0, if1.overflow}, 8'd0);
      chk("pulse_busy_end", {7'd0, if1.busy},     8'd0);

      // req held for 6 edges: ack back-to-back, accept and retire cancel
      if1.req = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (if1.ack) acks++;
         chk("hold_ack",  {7'd0, if1.ack},      8'd1);
         chk("hold_pend", {4'd0, if1.pend_cnt}, 8'd1);
      end
      if1.req = 1'b0;
      tick();
      chk("hold_ack_drop", {7'd0, if1.ack},      8'd0);
      chk("hold_pend_end", {4'd0, if1.pend_cnt}, 8'd0);
      chk("hold_ack_cnt",  acks[7:0],            8'd6);

      // Stalled burst of 6: saturate at 4, 5th sets overflow
      if1.stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if1.req = 1'b1;
         tick();
         chk("stall_pend", {4'd0, if1.pend_cnt}, {4'd0, exp_pend[i]});
         chk("stall_ack",  {7'd0, if1.ack},      8'd0);
         chk("stall_ovf",  {7'd0, if1.overflow}, (i >= 4) ? 8'd1 : 8'd0);
      end
      if1.req   = 1'b0;
      if1.stall = 1'b0;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (if1.ack) acks++;
      end
      chk("drain_acks", acks[7:0],            8'd4);
      chk("drain_pend", {4'd0, if1.pend_cnt}, 8'd0);
      chk("drain_ovf",  {7'd0, if1.overflow}, 8'd1);

      // Reset mid-way with three pending
      if1.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if1.req = 1'b1;
         tick();
      end
      if1.req = 1'b0;
      chk("pre_rst_pend", {4'd0, if1.pend_cnt}, 8'd3);
      #3 rst = 1'b1;                          // between edges
      #1;
      chk("arst_ack",  {7'd0, if1.ack},      8'd0);
      chk("arst_pend", {4'd0, if1.pend_cnt}, 8'd0);
      chk("arst_ovf",  {7'd0, if1.overflow}, 8'd0);
      chk("arst_busy", {7'd0, if1.busy},     8'd0);
      #1 rst = 1'b0;
      if1.stall = 1'b0;

      // LATENCY=3: req at edge 2 after release, ack sampled at edge 5 only
      acks = 0;
      tick();                                 // edge 1
      if (if1.ack) acks++;
      if3.req = 1'b1;
      tick();                                 // edge 2
      if (if1.ack) acks++;
      if3.req = 1'b0;
      chk("lat3_e3", {7'd0, if3.ack}, 8'd0);
      tick();                                 // edge 3
      if (if1.ack) acks++;
      chk("lat3_e4", {7'd0, if3.ack}, 8'd0);
      tick();                                 // edge 4
      if (if1.ack) acks++;
      chk("lat3_e5",      {7'd0, if3.ack},      8'd1);
      chk("lat3_pend_e5", {4'd0, if3.pend_cnt}, 8'd1);
      tick();                                 // edge 5
      if (if1.ack) acks++;
      chk("lat3_e6",      {7'd0, if3.ack},      8'd0);
      chk("lat3_pend_e6", {4'd0, if3.pend_cnt}, 8'd0);
      chk("post_rst_acks", acks[7:0],            8'd0);
      chk("post_rst_pend", {4'd0, if1.pend_cnt}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
